// File: rtl/wd_multi_timer_pkg.sv
// wd_multi_timer_pkg: shared channel state encoding and edge-mode selectors
package wd_multi_timer_pkg;
  typedef enum logic [1:0] {
    WD_IDLE    = 2'b00,
    WD_ARMED   = 2'b01,
    WD_TRIPPED = 2'b10
  } wd_state_e;
  localparam int EDGE_ANY  = 0;
  localparam int EDGE_RISE = 1;
endpackage

// File: rtl/wd_multi_timer_channel.sv
// wd_multi_timer_channel: one heartbeat channel with synchroniser, pet detect, arm/trip FSM and timeout counter
module wd_multi_timer_channel import wd_multi_timer_pkg::*; #(
  parameter int TIMEOUT   = 126,
  parameter int EDGE_MODE = EDGE_ANY,
  localparam int CNT_W    = $clog2(TIMEOUT)
) (
  input  logic clk_1khz,
  input  logic rst,
  input  logic wd_in,
  input  logic wd_en,
  input  logic wd_clr,
  output logic wd_trip
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);
  wd_state_e state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic s1, s2, s3, pet, run;
  assign pet = (EDGE_MODE == EDGE_RISE) ? (s2 & ~s3) : (s2 ^ s3);
  assign run = (state == WD_ARMED) && wd_en && !pet;
  always_ff @(posedge clk_1khz) begin
    if (rst) begin
      {s1, s2, s3} <= '0;
      state <= WD_IDLE;
      cnt <= '0;
      wd_trip <= 1'b0;
    end else begin
      {s1, s2, s3} <= {wd_in, s1, s2};
      state <= state_n;
      cnt <= cnt_n;
      wd_trip <= state_n == WD_TRIPPED;
    end
  end
  // disable beats timeout, a pet on the last count beats the trip
  always_comb begin
    state_n = state == WD_IDLE    ? (wd_en ? WD_ARMED : WD_IDLE)
            : state == WD_ARMED   ? (!wd_en ? WD_IDLE : (!pet && cnt == LAST) ? WD_TRIPPED : WD_ARMED)
            : state == WD_TRIPPED ? (!wd_clr ? WD_TRIPPED : wd_en ? WD_ARMED : WD_IDLE)
            : WD_IDLE;
  end
  // counter saturates at LAST on the trip and stays frozen until cleared
  always_comb begin
    cnt_n = (run && cnt != LAST) ? cnt + 1'b1
          : (run || (state == WD_TRIPPED && !wd_clr)) ? cnt
          : '0;
  end
endmodule

// File: rtl/wd_multi_timer.sv
// wd_multi_timer: N-channel heartbeat watchdog with sticky trips, shutdown request and first-fault capture
module wd_multi_timer import wd_multi_timer_pkg::*; #(
  parameter int N_CH      = 4,
  parameter int TIMEOUT   = 126,
  parameter int EDGE_MODE = EDGE_ANY,
  localparam int IDX_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk_1khz,
  input  logic             rst,
  input  logic [N_CH-1:0]  wd_in,
  input  logic [N_CH-1:0]  wd_en,
  input  logic [N_CH-1:0]  wd_clr,
  output logic [N_CH-1:0]  wd_trip,
  output logic             wd_out,
  output logic [IDX_W-1:0] wd_first,
  output logic             wd_first_v
);
  logic [IDX_W-1:0] low_idx;
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    wd_multi_timer_channel #(.TIMEOUT(TIMEOUT), .EDGE_MODE(EDGE_MODE)) u_ch (
      .clk_1khz(clk_1khz),
      .rst(rst),
      .wd_in(wd_in[i]),
      .wd_en(wd_en[i]),
      .wd_clr(wd_clr[i]),
      .wd_trip(wd_trip[i])
    );
  end
  always_comb begin
    low_idx = '0;
    for (int k = N_CH - 1; k >= 0; k--)
      if (wd_trip[k]) low_idx = IDX_W'(k);
  end
  // first fault latches only while empty, and empties once every trip is cleared
  always_ff @(posedge clk_1khz) begin
    if (rst) begin
      wd_out <= 1'b0;
      wd_first <= '0;
      wd_first_v <= 1'b0;
    end else begin
      wd_out <= |wd_trip;
      if (!wd_first_v && |wd_trip) begin
        wd_first <= low_idx;
        wd_first_v <= 1'b1;
      end else if (wd_first_v && !(|wd_trip)) begin
        wd_first <= '0;
        wd_first_v <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_wd_multi_timer.sv
// tb_wd_multi_timer: any-edge and rising-edge watchdogs on shared stimulus, checked against an elapsed-time model
module tb_wd_multi_timer;
  localparam int TO = 126;
  logic clk = 1'b0;
  logic rst;
  logic [3:0] wd_in, wd_en, wd_clr;
  logic [3:0] trip_a, trip_r;
  logic out_a, out_r, fv_a, fv_r;
  logic [1:0] first_a, first_r;
  int checks = 0;
  int failures = 0;
  int ecnt;
  logic [3:0] plog [0:16383];
  logic [3:0] m_armed [2];
  logic [3:0] m_trip [2];
  int m_last [2][4];
  logic m_out [2];
  logic [1:0] m_first [2];
  logic m_fv [2];

  always #5 clk = ~clk;

  wd_multi_timer #(.N_CH(4), .TIMEOUT(TO), .EDGE_MODE(0)) dut_any (
    .clk_1khz(clk), .rst(rst), .wd_in(wd_in), .wd_en(wd_en), .wd_clr(wd_clr),
    .wd_trip(trip_a), .wd_out(out_a), .wd_first(first_a), .wd_first_v(fv_a));
  wd_multi_timer #(.N_CH(4), .TIMEOUT(TO), .EDGE_MODE(1)) dut_rise (
    .clk_1khz(clk), .rst(rst), .wd_in(wd_in), .wd_en(wd_en), .wd_clr(wd_clr),
    .wd_trip(trip_r), .wd_out(out_r), .wd_first(first_r), .wd_first_v(fv_r));

  function automatic logic [1:0] lowest(input logic [3:0] v);
    logic [1:0] r = 2'd0;
    for (int i = 3; i >= 0; i--) if (v[i]) r = 2'(i);
    return r;
  endfunction

  function automatic logic [7:0] obs(input int md);
    return md == 1 ? {trip_r, out_r, first_r, fv_r} : {trip_a, out_a, first_a, fv_a};
  endfunction

  function automatic logic [7:0] exp_v(input int md);
    return {m_trip[md], m_out[md], m_first[md], m_fv[md]};
  endfunction

  // pin sampled at edge e is seen as a pet at edge e+2; a channel trips TO edges after its last clear
  task automatic model_update();
    logic [3:0] prev;
    logic p2, p3, pet;
    ecnt++;
    plog[ecnt] = rst ? 4'b0 : wd_in;
    if (rst) begin
      plog[ecnt-1] = 4'b0;
      plog[ecnt-2] = 4'b0;
      for (int md = 0; md < 2; md++) begin
        m_armed[md] = 4'b0; m_trip[md] = 4'b0; m_out[md] = 1'b0; m_first[md] = 2'd0; m_fv[md] = 1'b0;
      end
    end else begin
      for (int md = 0; md < 2; md++) begin
        prev = m_trip[md];
        for (int c = 0; c < 4; c++) begin
          p2 = plog[ecnt-2][c];
          p3 = plog[ecnt-3][c];
          pet = (md == 1) ? (p2 & ~p3) : (p2 ^ p3);
          if (m_trip[md][c]) begin
            if (wd_clr[c]) begin m_trip[md][c] = 1'b0; m_armed[md][c] = wd_en[c]; m_last[md][c] = ecnt; end
          end else if (m_armed[md][c]) begin
            if (!wd_en[c]) m_armed[md][c] = 1'b0;
            else if (pet) m_last[md][c] = ecnt;
            else if (ecnt - m_last[md][c] == TO) begin m_trip[md][c] = 1'b1; m_armed[md][c] = 1'b0; end
          end else if (wd_en[c]) begin
            m_armed[md][c] = 1'b1; m_last[md][c] = ecnt;
          end
        end
        m_out[md] = |prev;
        if (!m_fv[md] && |prev) begin m_fv[md] = 1'b1; m_first[md] = lowest(prev); end
        else if (m_fv[md] && prev == 4'b0) begin m_fv[md] = 1'b0; m_first[md] = 2'd0; end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; wd_in = 4'b0; wd_en = 4'b0; wd_clr = 4'b0;
    step(); step();
    rst = 1'b0;
    for (int md = 0; md < 2; md++) begin
      checks++;
      if (obs(md) !== 8'b0) begin failures++; $display("FAIL reset md=%0d got=%b exp=%b", md, obs(md), 8'b0); end
    end
  endtask

  task automatic test_keep_alive();
    int gap = int'($urandom_range(30, 60));
    wd_en = 4'b0001;
    for (int k = 0; k < 2000; k++) begin
      if (k % gap == gap - 1) wd_in[0] = ~wd_in[0];
      step();
      checks++;
      if ({trip_a, out_a, trip_r, out_r} !== 10'b0) begin
        failures++; $display("FAIL keep_alive e=%0d got=%b exp=0", ecnt, {trip_a, out_a, trip_r, out_r});
      end
      for (int md = 0; md < 2; md++) begin
        checks++;
        if (obs(md) !== exp_v(md)) begin failures++; $display("FAIL keep_alive_model md=%0d e=%0d got=%b exp=%b", md, ecnt, obs(md), exp_v(md)); end
      end
    end
  endtask

  task automatic test_timeout();
    int t = ecnt + 3;
    wd_in[0] = ~wd_in[0];
    while (ecnt < t + TO - 1) begin
      step();
      checks++;
      if (trip_a[0] !== 1'b0) begin failures++; $display("FAIL timeout_early e=%0d got=%b exp=0", ecnt, trip_a[0]); end
      for (int md = 0; md < 2; md++) begin
        checks++;
        if (obs(md) !== exp_v(md)) begin failures++; $display("FAIL timeout_model md=%0d e=%0d got=%b exp=%b", md, ecnt, obs(md), exp_v(md)); end
      end
    end
    step();
    checks++;
    if ({trip_a[0], out_a} !== 2'b10) begin failures++; $display("FAIL timeout_trip got=%b exp=10", {trip_a[0], out_a}); end
    step();
    checks++;
    if ({out_a, first_a, fv_a} !== 4'b1001) begin failures++; $display("FAIL timeout_first got=%b exp=1001", {out_a, first_a, fv_a}); end
    wd_clr = 4'b0001; step(); wd_clr = 4'b0;
    checks++;
    if (trip_a[0] !== 1'b0) begin failures++; $display("FAIL timeout_clr got=%b exp=0", trip_a[0]); end
    step();
    checks++;
    if ({fv_a, out_a} !== 2'b00) begin failures++; $display("FAIL timeout_fv_drop got=%b exp=00", {fv_a, out_a}); end
    for (int md = 0; md < 2; md++) begin
      checks++;
      if (obs(md) !== exp_v(md)) begin failures++; $display("FAIL timeout_model md=%0d e=%0d got=%b exp=%b", md, ecnt, obs(md), exp_v(md)); end
    end
  endtask

  task automatic test_pet_boundary();
    int t = ecnt + 3;
    int t2;
    wd_in[0] = ~wd_in[0];
    while (ecnt < t + TO - 3) step();
    wd_in[0] = ~wd_in[0];
    while (ecnt < t + TO) begin
      step();
      for (int md = 0; md < 2; md++) begin
        checks++;
        if (obs(md) !== exp_v(md)) begin failures++; $display("FAIL boundary_model md=%0d e=%0d got=%b exp=%b", md, ecnt, obs(md), exp_v(md)); end
      end
    end
    step();
    checks++;
    if (trip_a[0] !== 1'b0) begin failures++; $display("FAIL boundary_pet_wins got=%b exp=0", trip_a[0]); end
    t2 = t + TO;
    while (ecnt < t2 + TO - 2) step();
    wd_in[0] = ~wd_in[0];
    step();
    checks++;
    if (trip_a[0] !== 1'b0) begin failures++; $display("FAIL boundary_pre got=%b exp=0", trip_a[0]); end
    step();
    checks++;
    if (trip_a[0] !== 1'b1) begin failures++; $display("FAIL boundary_late_pet got=%b exp=1", trip_a[0]); end
    step(); step();
    checks++;
    if (trip_a[0] !== 1'b1) begin failures++; $display("FAIL boundary_sticky got=%b exp=1", trip_a[0]); end
    for (int md = 0; md < 2; md++) begin
      checks++;
      if (obs(md) !== exp_v(md)) begin failures++; $display("FAIL boundary_model md=%0d e=%0d got=%b exp=%b", md, ecnt, obs(md), exp_v(md)); end
    end
    wd_clr = 4'b0001; step(); wd_clr = 4'b0;
  endtask

  task automatic test_simultaneous();
    int a;
    wd_en = 4'b0; wd_clr = 4'hf; step(); wd_clr = 4'b0; step(); step();
    wd_en = 4'b1010;
    step();
    a = ecnt;
    while (ecnt < a + TO - 1) step();
    checks++;
    if ({trip_a, trip_r} !== 8'b0) begin failures++; $display("FAIL simul_early got=%b exp=0", {trip_a, trip_r}); end
    step();
    checks++;
    if ({trip_a, trip_r} !== 8'b1010_1010) begin failures++; $display("FAIL simul_trip got=%b exp=10101010", {trip_a, trip_r}); end
    step();
    checks++;
    if ({out_a, first_a, fv_a} !== 4'b1011) begin failures++; $display("FAIL simul_first got=%b exp=1011", {out_a, first_a, fv_a}); end
    wd_clr = 4'b0010; step(); wd_clr = 4'b0;
    checks++;
    if ({trip_a, first_a, fv_a} !== 7'b1000_011) begin failures++; $display("FAIL simul_clr1 got=%b exp=1000011", {trip_a, first_a, fv_a}); end
    wd_clr = 4'b1000; step(); wd_clr = 4'b0;
    checks++;
    if ({trip_a, fv_a} !== 5'b0000_1) begin failures++; $display("FAIL simul_clr3 got=%b exp=00001", {trip_a, fv_a}); end
    step();
    checks++;
    if (fv_a !== 1'b0) begin failures++; $display("FAIL simul_fv_drop got=%b exp=0", fv_a); end
    for (int md = 0; md < 2; md++) begin
      checks++;
      if (obs(md) !== exp_v(md)) begin failures++; $display("FAIL simul_model md=%0d e=%0d got=%b exp=%b", md, ecnt, obs(md), exp_v(md)); end
    end
    wd_en = 4'b0; step();
  endtask

  task automatic test_edge_mode();
    int a;
    wd_en = 4'b0; wd_clr = 4'hf; step(); wd_clr = 4'b0;
    wd_in[2] = 1'b1;
    repeat (5) step();
    wd_en = 4'b0100;
    step();
    a = ecnt;
    while (ecnt < a + 49) step();
    wd_in[2] = 1'b0;
    while (ecnt < a + TO - 1) step();
    checks++;
    if ({trip_a[2], trip_r[2]} !== 2'b00) begin failures++; $display("FAIL edge_early got=%b exp=00", {trip_a[2], trip_r[2]}); end
    step();
    checks++;
    if ({trip_a, trip_r} !== 8'b0000_0100) begin failures++; $display("FAIL edge_rise_trip got=%b exp=00000100", {trip_a, trip_r}); end
    while (ecnt < a + 52 + TO - 1) step();
    checks++;
    if (trip_a[2] !== 1'b0) begin failures++; $display("FAIL edge_any_early got=%b exp=0", trip_a[2]); end
    step();
    checks++;
    if (trip_a[2] !== 1'b1) begin failures++; $display("FAIL edge_any_trip got=%b exp=1", trip_a[2]); end
    for (int md = 0; md < 2; md++) begin
      checks++;
      if (obs(md) !== exp_v(md)) begin failures++; $display("FAIL edge_model md=%0d e=%0d got=%b exp=%b", md, ecnt, obs(md), exp_v(md)); end
    end
    wd_en = 4'b0; wd_clr = 4'hf; step(); wd_clr = 4'b0;
  endtask

  task automatic test_reset_mid();
    int a, r;
    wd_en = 4'b0; wd_clr = 4'hf; step(); wd_clr = 4'b0;
    wd_in[0] = 1'b0; wd_in[1] = 1'b1;
    repeat (5) step();
    wd_en = 4'b0001;
    step();
    a = ecnt;
    while (ecnt < a + 65) step();
    wd_en = 4'b0011;
    while (ecnt < a + TO) step();
    checks++;
    if (trip_a !== 4'b0001) begin failures++; $display("FAIL rstmid_pre got=%b exp=0001", trip_a); end
    rst = 1'b1; step(); rst = 1'b0;
    r = ecnt;
    for (int md = 0; md < 2; md++) begin
      checks++;
      if (obs(md) !== 8'b0) begin failures++; $display("FAIL rstmid_clear md=%0d got=%b exp=0", md, obs(md)); end
    end
    while (ecnt < r + TO) step();
    checks++;
    if ({trip_a, trip_r} !== 8'b0) begin failures++; $display("FAIL rstmid_early got=%b exp=0", {trip_a, trip_r}); end
    step();
    checks++;
    if ({trip_a, trip_r} !== 8'b0001_0001) begin failures++; $display("FAIL rstmid_ch0 got=%b exp=00010001", {trip_a, trip_r}); end
    step(); step();
    checks++;
    if ({trip_a, trip_r} !== 8'b0011_0011) begin failures++; $display("FAIL rstmid_ch1 got=%b exp=00110011", {trip_a, trip_r}); end
    for (int md = 0; md < 2; md++) begin
      checks++;
      if (obs(md) !== exp_v(md)) begin failures++; $display("FAIL rstmid_model md=%0d e=%0d got=%b exp=%b", md, ecnt, obs(md), exp_v(md)); end
    end
    wd_en = 4'b0; wd_clr = 4'hf; step(); wd_clr = 4'b0;
  endtask

  task automatic test_random();
    wd_en = 4'($urandom);
    for (int k = 0; k < 3000; k++) begin
      rst = ($urandom_range(0, 999) == 0);
      for (int c = 0; c < 4; c++) begin
        if ($urandom_range(0, 39) == 0) wd_in[c] = ~wd_in[c];
        if ($urandom_range(0, 299) == 0) wd_en[c] = ~wd_en[c];
        wd_clr[c] = ($urandom_range(0, 59) == 0);
      end
      step();
      for (int md = 0; md < 2; md++) begin
        checks++;
        if (obs(md) !== exp_v(md)) begin failures++; $display("FAIL random_model md=%0d e=%0d got=%b exp=%b", md, ecnt, obs(md), exp_v(md)); end
      end
    end
    rst = 1'b0; wd_clr = 4'b0;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) plog[i] = 4'b0;
    ecnt = 3;
    for (int md = 0; md < 2; md++) begin
      m_armed[md] = 4'b0; m_trip[md] = 4'b0; m_out[md] = 1'b0; m_first[md] = 2'd0; m_fv[md] = 1'b0;
      for (int c = 0; c < 4; c++) m_last[md][c] = 0;
    end
    test_reset();
    test_keep_alive();
    test_timeout();
    test_pet_boundary();
    test_simultaneous();
    test_edge_mode();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL time_limit checks=%0d", checks);
    $fatal(1, "time limit");
  end
endmodule
